// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - Shares the SDRAM command controller between refresh, camera writes and display reads.
// Optional feature macro SDRAM_ARB_RR_EN: writes and reads alternate when both request.
module sdram_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int REF_PERIOD = 1040,
  parameter int CNT_W      = 11
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              wr_ack,
  output logic              rd_ack,
  output logic              op_valid,
  output logic [1:0]        op_code,
  output logic [ADDR_W-1:0] op_addr,
  input  logic              op_done,
  output logic              ref_miss
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_REF,
    S_WR,
    S_RD,
    S_DONE
  } state_t;

  localparam logic [1:0]       OP_NONE  = 2'b00;
  localparam logic [1:0]       OP_REF   = 2'b01;
  localparam logic [1:0]       OP_WR    = 2'b10;
  localparam logic [1:0]       OP_RD    = 2'b11;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REF_PERIOD - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ref_pending_q, ref_pending_d;
  logic                ref_miss_q, ref_miss_d;
  logic                wr_req_q, rd_req_q;
  logic [ADDR_W-1:0]   wr_addr_q, rd_addr_q;
  logic                op_valid_q, op_valid_d;
  logic [1:0]          op_code_q, op_code_d;
  logic [ADDR_W-1:0]   op_addr_q, op_addr_d;
  logic                wr_ack_q, wr_ack_d;
  logic                rd_ack_q, rd_ack_d;
  logic                ref_expire;
  logic                ref_done;
  logic                wr_wins;

`ifdef SDRAM_ARB_RR_EN
  // 1 = the last write/read grant went to the read side, so a write wins the next tie
  logic                last_rd_q, last_rd_d;

  assign wr_wins = wr_req_q && (!rd_req_q || last_rd_q);
`else
  assign wr_wins = wr_req_q;
`endif

  // Requests and addresses are sampled once so arbitration never sees a mid-cycle change
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
    end else begin
      wr_req_q  <= wr_req;
      rd_req_q  <= rd_req;
      wr_addr_q <= wr_addr;
      rd_addr_q <= rd_addr;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    ref_expire = 1'b0;
    if (state_q != S_INIT) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d      = '0;
        ref_expire = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign ref_done = (state_q == S_REF) && op_done;

  // A new expiry landing on the completion cycle re-arms the request instead of counting as a miss
  always_comb begin
    ref_pending_d = ref_pending_q;
    if (ref_expire) begin
      ref_pending_d = 1'b1;
    end else if (ref_done) begin
      ref_pending_d = 1'b0;
    end
    ref_miss_d = ref_miss_q | (ref_expire & ref_pending_q & ~ref_done);
  end

  always_comb begin
    state_d    = state_q;
    op_valid_d = op_valid_q;
    op_code_d  = op_code_q;
    op_addr_d  = op_addr_q;
    wr_ack_d   = 1'b0;
    rd_ack_d   = 1'b0;
`ifdef SDRAM_ARB_RR_EN
    last_rd_d  = last_rd_q;
`endif
    case (state_q)
      S_INIT: begin
        if (init_done) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (ref_pending_q) begin
          state_d    = S_REF;
          op_valid_d = 1'b1;
          op_code_d  = OP_REF;
          op_addr_d  = '0;
        end else if (wr_wins) begin
          state_d    = S_WR;
          op_valid_d = 1'b1;
          op_code_d  = OP_WR;
          op_addr_d  = wr_addr_q;
`ifdef SDRAM_ARB_RR_EN
          last_rd_d  = 1'b0;
`endif
        end else if (rd_req_q) begin
          state_d    = S_RD;
          op_valid_d = 1'b1;
          op_code_d  = OP_RD;
          op_addr_d  = rd_addr_q;
`ifdef SDRAM_ARB_RR_EN
          last_rd_d  = 1'b1;
`endif
        end
      end
      S_REF, S_WR, S_RD: begin
        if (op_done) begin
          state_d    = S_DONE;
          op_valid_d = 1'b0;
          op_code_d  = OP_NONE;
          op_addr_d  = '0;
          wr_ack_d   = (state_q == S_WR);
          rd_ack_d   = (state_q == S_RD);
        end
      end
      S_DONE: begin
        // One dead cycle so the acked requester's dropped req reaches the input register
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_INIT;
      cnt_q         <= '0;
      ref_pending_q <= 1'b0;
      ref_miss_q    <= 1'b0;
      op_valid_q    <= 1'b0;
      op_code_q     <= OP_NONE;
      op_addr_q     <= '0;
      wr_ack_q      <= 1'b0;
      rd_ack_q      <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
      last_rd_q     <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ref_pending_q <= ref_pending_d;
      ref_miss_q    <= ref_miss_d;
      op_valid_q    <= op_valid_d;
      op_code_q     <= op_code_d;
      op_addr_q     <= op_addr_d;
      wr_ack_q      <= wr_ack_d;
      rd_ack_q      <= rd_ack_d;
`ifdef SDRAM_ARB_RR_EN
      last_rd_q     <= last_rd_d;
`endif
    end
  end

  assign op_valid = op_valid_q;
  assign op_code  = op_code_q;
  assign op_addr  = op_addr_q;
  assign wr_ack   = wr_ack_q;
  assign rd_ack   = rd_ack_q;
  assign ref_miss = ref_miss_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - Scoreboard bench for sdram_arbiter with a transaction-level arbitration model.
module tb_sdram_arbiter;

  localparam int         AW    = 24;
  localparam int         REF_P = 16;
  localparam logic [1:0] OP_REF = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_RD  = 2'b11;
`ifdef SDRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          sclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init_done = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          op_done = 1'b0;
  logic          wr_ack, rd_ack, op_valid, ref_miss;
  logic [1:0]    op_code;
  logic [AW-1:0] op_addr;

  sdram_arbiter #(.ADDR_W(AW), .REF_PERIOD(REF_P), .CNT_W(5)) dut (
    .sclk(sclk), .rst_n(rst_n), .init_done(init_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .rd_req(rd_req), .rd_addr(rd_addr),
    .wr_ack(wr_ack), .rd_ack(rd_ack), .op_valid(op_valid), .op_code(op_code),
    .op_addr(op_addr), .op_done(op_done), .ref_miss(ref_miss)
  );

  always #5 sclk = ~sclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected addresses per requester, pushed when a request is raised
  logic [AW-1:0] wr_q[$];
  logic [AW-1:0] rd_q[$];

  // Model state: refresh due every REF_P edges after init, plus request history at each edge
  int   e = 0;
  bit   started = 0, m_pend = 0, m_miss = 0;
  bit   ref_at_edge = 0, wr_prev = 0, rd_prev = 0, wr_cur = 0, rd_cur = 0;
  bit   cur_is_ref = 0;

  // Controller-side knobs set by the stimulus
  int         hold_len = 0;
  logic [1:0] hold_code = 2'b00;
  bit         fixed3 = 0;
  bit         idle_phase = 0;

  initial begin
    bit clr;
    forever begin
      @(posedge sclk or negedge rst_n);
      if (!rst_n) begin
        started = 0; e = 0; m_pend = 0; m_miss = 0;
        ref_at_edge = 0; wr_prev = 0; rd_prev = 0; wr_cur = 0; rd_cur = 0;
      end else begin
        ref_at_edge = m_pend;
        wr_prev = wr_cur; rd_prev = rd_cur;
        wr_cur = wr_req;  rd_cur = rd_req;
        if (!started) begin
          if (init_done) begin
            started = 1; e = 0;
          end
        end else begin
          e++;
          clr = op_done && cur_is_ref;
          if (e % REF_P == 0) begin
            if (m_pend && !clr) m_miss = 1;
            m_pend = 1;
          end else if (clr) begin
            m_pend = 0;
          end
        end
      end
    end
  end

  // Monitor + controller: checks each grant against the model and completes ops
  initial begin
    bit            prev_valid = 0, done_pending = 0, last_rd_m = 1;
    int            cnt_down = 0, since_done = 99, last_ref_e = -1;
    logic [1:0]    cur_code = 2'b00, exp_code;
    logic [AW-1:0] cur_addr = '0, a;
    forever begin
      @(negedge sclk);
      if (!rst_n) begin
        op_done = 0; done_pending = 0; prev_valid = 0; cnt_down = 0;
        cur_is_ref = 0; last_rd_m = 1; since_done = 99; last_ref_e = -1;
      end else begin
        since_done++;
        if (!idle_phase) last_ref_e = -1;
        chk("ref_miss", ref_miss, m_miss);
        if (done_pending) begin
          op_done = 0; done_pending = 0;
          chk("done_valid", op_valid, 0);
          chk("done_code", op_code, 0);
          chk("done_wr_ack", wr_ack, cur_code == OP_WR);
          chk("done_rd_ack", rd_ack, cur_code == OP_RD);
          cur_is_ref = 0; prev_valid = 0; since_done = 0;
        end else begin
          chk("ack_idle", {wr_ack, rd_ack}, 2'b00);
          if (op_valid && !prev_valid) begin
            chk("grant_gap", since_done >= 2, 1);
            if (ref_at_edge) exp_code = OP_REF;
            else if (wr_prev && rd_prev) exp_code = (RR && !last_rd_m) ? OP_RD : OP_WR;
            else if (wr_prev) exp_code = OP_WR;
            else if (rd_prev) exp_code = OP_RD;
            else exp_code = 2'b00;
            chk("grant_code", op_code, exp_code);
            chk("grant_code_nonzero", op_code != 2'b00, 1);
            cur_code = op_code; cur_addr = op_addr; cur_is_ref = (op_code == OP_REF);
            case (op_code)
              OP_REF: begin
                chk("ref_addr", op_addr, 0);
                if (last_ref_e >= 0) chk("ref_period", e - last_ref_e, REF_P);
                last_ref_e = e;
              end
              OP_WR: begin
                chk("wr_q_nonempty", wr_q.size() > 0, 1);
                if (wr_q.size() > 0) begin
                  a = wr_q.pop_front();
                  chk("wr_addr", op_addr, a);
                end
                last_rd_m = 0;
              end
              OP_RD: begin
                chk("rd_q_nonempty", rd_q.size() > 0, 1);
                if (rd_q.size() > 0) begin
                  a = rd_q.pop_front();
                  chk("rd_addr", op_addr, a);
                end
                last_rd_m = 1;
              end
              default: ;
            endcase
            if (hold_len > 0 && op_code == hold_code) begin
              cnt_down = hold_len; hold_len = 0;
            end else if (fixed3) begin
              cnt_down = 3;
            end else begin
              cnt_down = $urandom_range(0, 5);
            end
          end else if (op_valid) begin
            chk("op_stable", {op_code, op_addr}, {cur_code, cur_addr});
          end
          prev_valid = op_valid;
          if (op_valid) begin
            if (cnt_down == 0) begin
              op_done = 1; done_pending = 1;
            end else begin
              cnt_down--;
            end
          end
        end
      end
    end
  end

  // Requester tasks start at a negedge and drop their req on the ack cycle
  task automatic do_wr(input logic [AW-1:0] a);
    int t = 0;
    wr_addr = a; wr_req = 1; wr_q.push_back(a);
    do begin @(negedge sclk); t++; end while (!wr_ack && t < 400);
    wr_req = 0;
    chk("wr_ack_seen", wr_ack, 1);
  endtask

  task automatic do_rd(input logic [AW-1:0] a);
    int t = 0;
    rd_addr = a; rd_req = 1; rd_q.push_back(a);
    do begin @(negedge sclk); t++; end while (!rd_ack && t < 400);
    rd_req = 0;
    chk("rd_ack_seen", rd_ack, 1);
  endtask

  task automatic rand_traffic(input int n);
    fork
      begin
        for (int i = 0; i < n; i++) begin
          repeat ($urandom_range(1, 4)) @(negedge sclk);
          do_wr(AW'($urandom));
        end
      end
      begin
        for (int j = 0; j < n; j++) begin
          repeat ($urandom_range(1, 4)) @(negedge sclk);
          do_rd(AW'($urandom));
        end
      end
    join
  endtask

  task automatic wait_wr_ack(input string name);
    int t = 0;
    do begin @(negedge sclk); t++; end while (!wr_ack && t < 200);
    chk(name, wr_ack, 1);
    wr_req = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int t;
    repeat (3) @(negedge sclk);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_op_code", op_code, 0);
    chk("rst_op_addr", op_addr, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_rd_ack", rd_ack, 0);
    chk("rst_ref_miss", ref_miss, 0);

    // Write held during init is not granted until init_done
    wr_addr = 24'hA5_0F00; wr_req = 1; wr_q.push_back(wr_addr);
    @(negedge sclk); rst_n = 1;
    seen = 0;
    repeat (50) begin @(negedge sclk); seen |= op_valid; end
    chk("init_hold", seen, 0);
    init_done = 1;
    @(negedge sclk); chk("init_grant_early", op_valid, 0);
    @(negedge sclk); chk("init_grant_valid", op_valid, 1);
    chk("init_grant_code", op_code, OP_WR);
    wait_wr_ack("init_wr_ack");

    // Single write with op_done eight cycles after grant
    @(negedge sclk);
    hold_code = OP_WR; hold_len = 8;
    do_wr(24'h12_3456);

    // Simultaneous write and read, then random traffic
    @(negedge sclk);
    fork
      do_wr(AW'($urandom));
      do_rd(AW'($urandom));
    join
    @(negedge sclk);
    rand_traffic(30);

    // Idle requesters: refresh alone, every REF_P cycles
    repeat (20) @(negedge sclk);
    fixed3 = 1; idle_phase = 1;
    repeat (90) @(negedge sclk);
    chk("idle_ref_miss", ref_miss, 0);
    idle_phase = 0; fixed3 = 0;

    // Long write spans two expiries; refresh then beats waiting write and read
    @(negedge sclk);
    hold_code = OP_WR; hold_len = 40;
    fork
      begin
        do_wr(AW'($urandom));
        @(negedge sclk);
        do_wr(AW'($urandom));
      end
      begin
        repeat (5) @(negedge sclk);
        do_rd(AW'($urandom));
      end
    join
    chk("ref_miss_set", ref_miss, 1);

    // Asynchronous reset in the middle of a read
    @(negedge sclk);
    hold_code = OP_RD; hold_len = 1000;
    rd_addr = AW'($urandom); rd_req = 1; rd_q.push_back(rd_addr);
    t = 0;
    do begin @(negedge sclk); t++; end while (!(op_valid && op_code == OP_RD) && t < 200);
    chk("rd_granted", op_valid && op_code == OP_RD, 1);
    #2;
    rst_n = 0; init_done = 0; rd_req = 0;
    #1;
    chk("mid_rst_op_valid", op_valid, 0);
    chk("mid_rst_rd_ack", rd_ack, 0);
    chk("mid_rst_op_code", op_code, 0);
    chk("mid_rst_ref_miss", ref_miss, 0);
    wr_q.delete(); rd_q.delete(); hold_len = 0;
    repeat (3) @(negedge sclk);
    wr_addr = AW'($urandom); wr_req = 1; wr_q.push_back(wr_addr);
    rst_n = 1;
    seen = 0;
    repeat (20) begin @(negedge sclk); seen |= op_valid; end
    chk("reinit_hold", seen, 0);
    init_done = 1;
    wait_wr_ack("reinit_wr_ack");
    @(negedge sclk);
    rand_traffic(10);
    repeat (10) @(negedge sclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
